// File: rtl/servo_pwm_pkg.sv
// Shared defaults and helpers for the servo PWM array: frame timing,
// command scaling, the legal pulse window and the slew limiter.
package servo_pwm_pkg;

   localparam int PWM_CNT_W     = 10;
   localparam int PWM_PERIOD    = 607;
   localparam int PWM_SCALE     = 2;
   localparam int PWM_MIN_MATCH = 229;
   localparam int PWM_MAX_MATCH = 371;
   localparam int PWM_DEF_MATCH = 300;

   typedef enum logic [1:0] {
      CMD_OK    = 2'd0,
      CMD_CLAMP = 2'd1,
      CMD_BADCH = 2'd2
   } cmd_status_e;

   // Move cur toward tgt by at most step; a step of 0 jumps straight to tgt.
   function automatic int slew_limit(input int cur, input int tgt, input int step);
      int diff;
      if (step <= 0) begin
         return tgt;
      end
      diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
      if (diff <= step) begin
         return tgt;
      end
      return (tgt > cur) ? (cur + step) : (cur - step);
   endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One PWM channel: shadow and active match, enable latch, slew limiter and
// a compare whose result is registered so pwm_o comes straight from a flop.
module servo_pwm_ch
   import servo_pwm_pkg::*;
#(
   parameter int CNT_W     = PWM_CNT_W,
   parameter int DEF_MATCH = PWM_DEF_MATCH,
   parameter int SLEW_STEP = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [CNT_W-1:0] wr_val_i,
   input  logic             wrap_i,
   input  logic [CNT_W-1:0] cnt_next_i,
   input  logic             en_i,
   output logic             pwm_o
);

   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] active_q, active_d;
   logic             en_q, en_d;
   logic             pwm_q, pwm_d;

   // The wrap copy reads shadow_q, so a command landing in the wrap cycle
   // only reaches the active match one frame later.
   always_comb begin
      shadow_d = wr_en_i ? wr_val_i : shadow_q;
      active_d = active_q;
      en_d     = en_q;
      if (wrap_i) begin
         active_d = CNT_W'(slew_limit(int'(active_q), int'(shadow_q), SLEW_STEP));
         en_d     = en_i;
      end
      pwm_d = en_d && (cnt_next_i < active_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= CNT_W'(DEF_MATCH);
         active_q <= CNT_W'(DEF_MATCH);
         en_q     <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         en_q     <= en_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: shared frame counter, command decode
// with range clamping, and NUM_CH independent channel slices.
module servo_pwm_array
   import servo_pwm_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CMD_W     = 8,
   parameter int CNT_W     = PWM_CNT_W,
   parameter int PERIOD    = PWM_PERIOD,
   parameter int SCALE     = PWM_SCALE,
   parameter int MIN_MATCH = PWM_MIN_MATCH,
   parameter int MAX_MATCH = PWM_MAX_MATCH,
   parameter int DEF_MATCH = PWM_DEF_MATCH,
   parameter int SLEW_STEP = 0,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [CMD_W-1:0]  cmd_data,
   output logic              cmd_err,
   input  logic [NUM_CH-1:0] en,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start
);

   localparam int SW = CMD_W + CNT_W;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wrap;
   logic [SW-1:0]     scaled;
   cmd_status_e       status;
   logic [CNT_W-1:0]  wr_val;
   logic [NUM_CH-1:0] wr_en;
   logic              cmd_err_q, cmd_err_d;

   assign wrap        = (cnt_q == CNT_W'(PERIOD - 1));
   assign cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
   assign frame_start = (cnt_q == '0);

   // Scale at full width so oversized commands cannot alias into the window.
   assign scaled = SW'(cmd_data) * SW'(SCALE);

   always_comb begin
      status = CMD_OK;
      if (int'(cmd_ch) >= NUM_CH) begin
         status = CMD_BADCH;
      end else if ((scaled < SW'(MIN_MATCH)) || (scaled > SW'(MAX_MATCH))) begin
         status = CMD_CLAMP;
      end
   end

   assign wr_val    = (status == CMD_OK) ? scaled[CNT_W-1:0] : CNT_W'(DEF_MATCH);
   assign cmd_err_d = cmd_valid && (status != CMD_OK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   assign cmd_err = cmd_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign wr_en[gi] = cmd_valid && (status != CMD_BADCH) && (cmd_ch == CH_W'(gi));

         servo_pwm_ch #(
            .CNT_W     (CNT_W),
            .DEF_MATCH (DEF_MATCH),
            .SLEW_STEP (SLEW_STEP)
         ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (wr_en[gi]),
            .wr_val_i   (wr_val),
            .wrap_i     (wrap),
            .cnt_next_i (cnt_d),
            .en_i       (en[gi]),
            .pwm_o      (pwm_out[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_servo_pwm_array.sv
// Bench for servo_pwm_array: a default build and a 3-channel slew-limited
// build share stimulus and are compared against a frame-level model.
module tb_servo_pwm_array;

   localparam int PERIOD = 607;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_ch    = 2'd0;
   logic [7:0] cmd_data  = 8'd0;
   logic [3:0] en        = 4'hF;

   logic       err0, err1, fs0, fs1;
   logic [3:0] pwm0;
   logic [2:0] pwm1;

   int checks  = 0;
   int errors  = 0;
   bit started = 1'b0;

   // Frame-level model state: [0] = default build, [1] = NUM_CH=3, SLEW_STEP=16.
   int m_pos;
   int m_sh  [2][4];
   int m_act [2][4];
   bit m_en  [2][4];
   bit m_err [2];

   int hi0 [4];
   int hi1 [3];
   int exp_slew [6] = '{316, 332, 348, 364, 370, 370};

   always #5 clk = ~clk;

   servo_pwm_array dut0 (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ch      (cmd_ch),
      .cmd_data    (cmd_data),
      .cmd_err     (err0),
      .en          (en),
      .pwm_out     (pwm0),
      .frame_start (fs0)
   );

   servo_pwm_array #(.NUM_CH(3), .SLEW_STEP(16)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ch      (cmd_ch),
      .cmd_data    (cmd_data),
      .cmd_err     (err1),
      .en          (en[2:0]),
      .pwm_out     (pwm1),
      .frame_start (fs1)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int nch_of(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic int step_of(input int d);
      return (d == 0) ? 0 : 16;
   endfunction

   function automatic int scaled_cmd();
      return int'(cmd_data) * 2;
   endfunction

   function automatic bit in_window(input int v);
      return (v >= 229) && (v <= 371);
   endfunction

   function automatic bit ch_ok(input int d);
      return int'(cmd_ch) < nch_of(d);
   endfunction

   function automatic int toward(input int cur, input int tgt, input int step);
      if (step == 0) return tgt;
      if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
      return (cur - tgt > step) ? cur - step : tgt;
   endfunction

   function automatic int exp_pwm(input int d);
      int v = 0;
      for (int i = 0; i < nch_of(d); i++) begin
         if (m_en[d][i] && (m_pos < m_act[d][i])) v = v | (1 << i);
      end
      return v;
   endfunction

   // Model: frame position, per-channel shadow/active/enable, error pulse.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pos <= 0;
         for (int d = 0; d < 2; d++) begin
            m_err[d] <= 1'b0;
            for (int i = 0; i < 4; i++) begin
               m_sh[d][i]  <= 300;
               m_act[d][i] <= 300;
               m_en[d][i]  <= 1'b0;
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_err[d] <= cmd_valid && !(ch_ok(d) && in_window(scaled_cmd()));
            if (m_pos == PERIOD - 1) begin
               for (int i = 0; i < nch_of(d); i++) begin
                  m_act[d][i] <= toward(m_act[d][i], m_sh[d][i], step_of(d));
                  m_en[d][i]  <= en[i];
               end
            end
            if (cmd_valid && ch_ok(d)) begin
               m_sh[d][cmd_ch] <= in_window(scaled_cmd()) ? scaled_cmd() : 300;
            end
         end
         m_pos <= (m_pos == PERIOD - 1) ? 0 : m_pos + 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("pwm0", int'(pwm0), exp_pwm(0));
         chk("pwm1", int'(pwm1), exp_pwm(1));
         chk("fs0", int'(fs0), int'(m_pos == 0));
         chk("fs1", int'(fs1), int'(m_pos == 0));
         chk("err0", int'(err0), int'(m_err[0]));
         chk("err1", int'(err1), int'(m_err[1]));
      end
   end

   // Align to a frame start, then count high cycles per channel over one frame.
   task automatic measure_frame();
      int guard;
      guard = 0;
      while (fs0 !== 1'b1 && guard < 2 * PERIOD) begin
         @(negedge clk);
         guard++;
      end
      chk("frame_sync", int'(fs0), 1);
      for (int i = 0; i < 4; i++) hi0[i] = 0;
      for (int i = 0; i < 3; i++) hi1[i] = 0;
      for (int c = 0; c < PERIOD; c++) begin
         for (int i = 0; i < 4; i++) hi0[i] += int'(pwm0[i]);
         for (int i = 0; i < 3; i++) hi1[i] += int'(pwm1[i]);
         @(negedge clk);
      end
      chk("frame_period", int'(fs0), 1);
      $display("frame hi0=%0d,%0d,%0d,%0d hi1=%0d,%0d,%0d",
               hi0[0], hi0[1], hi0[2], hi0[3], hi1[0], hi1[1], hi1[2]);
   endtask

   task automatic issue_cmd(input int ch, input int data, input int e0, input int e1);
      cmd_ch    = 2'(ch);
      cmd_data  = 8'(data);
      cmd_valid = 1'b1;
      $display("cmd ch=%0d data=%0d", ch, data);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("cmd_err0", int'(err0), e0);
      chk("cmd_err1", int'(err1), e1);
   endtask

   task automatic check_all(input string tag, input int v0, input int v1);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_d0_ch%0d", tag, i), hi0[i], v0);
      for (int i = 0; i < 3; i++) chk($sformatf("%s_d1_ch%0d", tag, i), hi1[i], v1);
   endtask

   initial begin
      @(negedge clk);
      started = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Enabled from reset: first frame dark, then default 300-cycle pulses.
      measure_frame();
      check_all("first", 0, 0);
      measure_frame();
      check_all("default", 300, 300);

      // Legal mid-frame command on channel 1 only.
      repeat (50) @(negedge clk);
      issue_cmd(1, 160, 0, 0);
      measure_frame();
      chk("b_d0_ch0", hi0[0], 300);
      chk("b_d0_ch1", hi0[1], 320);
      chk("b_d0_ch2", hi0[2], 300);
      chk("b_d0_ch3", hi0[3], 300);
      chk("b_d1_ch1", hi1[1], 316);

      // Out-of-window data and an out-of-range channel on the 3-channel build.
      repeat (5) @(negedge clk);
      issue_cmd(0, 100, 1, 1);
      issue_cmd(2, 255, 1, 1);
      issue_cmd(3, 150, 0, 1);
      measure_frame();
      chk("c_d0_ch0", hi0[0], 300);
      chk("c_d0_ch1", hi0[1], 320);
      chk("c_d0_ch2", hi0[2], 300);
      chk("c_d0_ch3", hi0[3], 300);
      chk("c_d1_ch0", hi1[0], 300);
      chk("c_d1_ch1", hi1[1], 320);
      chk("c_d1_ch2", hi1[2], 300);

      // Command in the wrap cycle applies one frame late.
      repeat (606) @(negedge clk);
      issue_cmd(2, 120, 0, 0);
      measure_frame();
      chk("d1_d0_ch2", hi0[2], 300);
      chk("d1_d1_ch2", hi1[2], 300);
      measure_frame();
      chk("d2_d0_ch2", hi0[2], 240);
      chk("d2_d1_ch2", hi1[2], 284);

      // Slew-limited ramp to 370.
      repeat (50) @(negedge clk);
      issue_cmd(0, 185, 0, 0);
      for (int f = 0; f < 6; f++) begin
         measure_frame();
         chk($sformatf("slew_f%0d_d1", f), hi1[0], exp_slew[f]);
         chk($sformatf("slew_f%0d_d0", f), hi0[0], 370);
      end

      // Randomized commands and enables, checked cycle by cycle by the model.
      for (int c = 0; c < 6 * PERIOD; c++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_ch    = 2'($urandom_range(0, 3));
         cmd_data  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(110, 190))
                                                 : 8'($urandom_range(0, 255));
         if ($urandom_range(0, 199) == 0) en = 4'($urandom);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      en        = 4'hF;

      // Asynchronous reset in the middle of the high phase.
      measure_frame();
      repeat (100) @(negedge clk);
      chk("pre_rst_pwm0", int'(pwm0), 15);
      chk("pre_rst_pwm1", int'(pwm1), 7);
      #2 rst = 1'b1;
      #1;
      chk("async_pwm0", int'(pwm0), 0);
      chk("async_pwm1", int'(pwm1), 0);
      chk("async_fs0", int'(fs0), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      measure_frame();
      check_all("post_rst_first", 0, 0);
      measure_frame();
      check_all("post_rst", 300, 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
